parking_dual_gate_scheduler: RTL and testbench

Occupancy controller for a parking lot with two gates (A, B). Each gate has an outer/inner sensor pair. A per-gate sequence FSM turns sensor activity into enter or exit events. A round-robin scheduler then serializes those events onto one shared, capacity-limited occupancy counter, whose value feeds the HEX display logic. Sensor inputs arrive already two-flop synchronized.

---
 rtl/parking_dual_gate_scheduler.sv | 89 ++++++++
 tb/tb_parking_dual_gate_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/parking_dual_gate_scheduler.sv
// parking_dual_gate_scheduler: two-gate sensor FSMs round-robin scheduled onto a saturating occupancy counter
module parking_dual_gate_scheduler #(
  parameter int CAPACITY = 25,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          outer_a,
  input  logic          inner_a,
  input  logic          outer_b,
  input  logic          inner_b,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          enter_pulse,
  output logic          exit_pulse,
  output logic          reject_pulse,
  output logic          served_gate
);
  typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3} state_t;
  state_t st [2];
  logic [1:0] sens [2];
  logic [1:0] done, is_enter, pend, kind;
  logic ptr, sel, serve;
  assign sens[0] = {outer_a, inner_a};
  assign sens[1] = {outer_b, inner_b};
  assign serve = |pend;
  assign sel = &pend ? ptr : pend[1];
  assign full = count == CW'(CAPACITY);
  assign empty = count == '0;
  function automatic state_t next_state(input state_t s, input logic [1:0] i);
    case (s)
      IDLE:    return i == 2'b10 ? EN1 : i == 2'b01 ? EX1 : IDLE;
      EN1:     return i == 2'b11 ? EN2 : i == 2'b00 ? IDLE : EN1;
      EN2:     return i == 2'b01 ? EN3 : i == 2'b10 ? EN1 : i == 2'b00 ? IDLE : EN2;
      EN3:     return i == 2'b00 ? IDLE : i == 2'b11 ? EN2 : EN3;
      EX1:     return i == 2'b11 ? EX2 : i == 2'b00 ? IDLE : EX1;
      EX2:     return i == 2'b10 ? EX3 : i == 2'b01 ? EX1 : i == 2'b00 ? IDLE : EX2;
      EX3:     return i == 2'b00 ? IDLE : i == 2'b11 ? EX2 : EX3;
      default: return IDLE;
    endcase
  endfunction
  always_comb begin
    done = '0;
    is_enter = '0;
    for (int g = 0; g < 2; g++) begin
      done[g] = (st[g] == EN3 || st[g] == EX3) && sens[g] == 2'b00;
      is_enter[g] = st[g] == EN3;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st[0] <= IDLE;
      st[1] <= IDLE;
      pend <= '0;
      kind <= '0;
      ptr <= 1'b0;
      count <= '0;
      enter_pulse <= 1'b0;
      exit_pulse <= 1'b0;
      reject_pulse <= 1'b0;
      served_gate <= 1'b0;
    end else begin
      enter_pulse <= 1'b0;
      exit_pulse <= 1'b0;
      reject_pulse <= 1'b0;
      for (int g = 0; g < 2; g++) begin
        st[g] <= next_state(st[g], sens[g]);
        pend[g] <= done[g] | (pend[g] & ~(serve && sel == 1'(g)));
        if (done[g]) kind[g] <= is_enter[g];
      end
      if (&pend) ptr <= ~ptr;
      if (serve) begin
        served_gate <= sel;
        if (kind[sel]) begin
          if (!full) begin
            count <= count + 1'b1;
            enter_pulse <= 1'b1;
          end else reject_pulse <= 1'b1;
        end else begin
          if (!empty) begin
            count <= count - 1'b1;
            exit_pulse <= 1'b1;
          end else reject_pulse <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_parking_dual_gate_scheduler.sv
// tb_parking_dual_gate_scheduler: randomized episode stimulus with queue scoreboard against an occupancy model
module tb_parking_dual_gate_scheduler;
  localparam int CAP = 25;
  localparam int CW = 5;
  logic clk = 0, reset = 1;
  logic outer_a = 0, inner_a = 0, outer_b = 0, inner_b = 0;
  logic [CW-1:0] count;
  logic full, empty, enter_pulse, exit_pulse, reject_pulse, served_gate;
  always #5 clk = ~clk;
  parking_dual_gate_scheduler #(.CAPACITY(CAP), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .outer_a(outer_a), .inner_a(inner_a), .outer_b(outer_b), .inner_b(inner_b),
    .count(count), .full(full), .empty(empty),
    .enter_pulse(enter_pulse), .exit_pulse(exit_pulse), .reject_pulse(reject_pulse),
    .served_gate(served_gate)
  );
  typedef struct {int typ; int g; int cnt;} exp_t;
  exp_t sb[$];
  logic [3:0] qa[$], qb[$];
  logic [1:0] comp [2];
  int checks = 0, fails = 0;
  int mcount = 0, mserved = 0, mptr = 0;
  int mp [2], mk [2];
  int contested = 0, full_rej = 0, empty_rej = 0;
  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask
  initial begin
    mp[0] = 0; mp[1] = 0; mk[0] = 0; mk[1] = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        mcount = 0; mserved = 0; mptr = 0; mp[0] = 0; mp[1] = 0;
        sb.delete();
      end else begin
        if (mp[0] != 0 || mp[1] != 0) begin
          int g, t;
          exp_t e;
          if (mp[0] != 0 && mp[1] != 0) begin
            g = mptr;
            mptr = 1 - mptr;
            contested++;
          end else g = mp[1] != 0 ? 1 : 0;
          mp[g] = 0;
          if (mk[g] != 0) begin
            if (mcount < CAP) begin mcount++; t = 0; end
            else begin t = 2; full_rej++; end
          end else begin
            if (mcount > 0) begin mcount--; t = 1; end
            else begin t = 2; empty_rej++; end
          end
          mserved = g;
          e.typ = t; e.g = g; e.cnt = mcount;
          sb.push_back(e);
        end
        for (int i = 0; i < 2; i++)
          if (comp[i] != 2'd0) begin
            mp[i] = 1;
            mk[i] = comp[i] == 2'd1 ? 1 : 0;
          end
      end
    end
  end
  initial begin
    forever begin
      logic [2:0] pl;
      @(negedge clk);
      chk("count", int'(count), mcount);
      chk("full", int'(full), int'(mcount == CAP));
      chk("empty", int'(empty), int'(mcount == 0));
      chk("served_gate", int'(served_gate), mserved);
      pl = {enter_pulse, exit_pulse, reject_pulse};
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("pulses", int'(pl), e.typ == 0 ? 4 : e.typ == 1 ? 2 : 1);
        chk("event_count", int'(count), e.cnt);
        chk("event_gate", int'(served_gate), e.g);
      end else chk("no_pulse", int'(pl), 0);
    end
  end
  task automatic push(input int g, input logic [1:0] s, input logic [1:0] c);
    if (g == 0) qa.push_back({s, c});
    else qb.push_back({s, c});
  endtask
  task automatic hold(input int g, input logic [1:0] s);
    repeat ($urandom_range(1, 2)) push(g, s, 2'd0);
  endtask
  task automatic basic(input int g, input bit enter);
    logic [1:0] f;
    f = enter ? 2'b10 : 2'b01;
    push(g, f, 2'd0);
    push(g, 2'b11, 2'd0);
    push(g, ~f, 2'd0);
    push(g, 2'b00, enter ? 2'd1 : 2'd2);
  endtask
  task automatic episode(input int g, input int kind);
    logic [1:0] f, l;
    if (kind <= 1) begin
      f = kind == 0 ? 2'b10 : 2'b01;
      l = ~f;
      hold(g, f);
      hold(g, 2'b11);
      repeat ($urandom_range(0, 2)) begin hold(g, f); hold(g, 2'b11); end
      hold(g, l);
      repeat ($urandom_range(0, 2)) begin hold(g, 2'b11); hold(g, l); end
      push(g, 2'b00, kind == 0 ? 2'd1 : 2'd2);
    end else if (kind == 2) begin
      f = $urandom_range(0, 1) != 0 ? 2'b10 : 2'b01;
      hold(g, f);
      if ($urandom_range(0, 1) != 0) hold(g, 2'b11);
      push(g, 2'b00, 2'd0);
    end else begin
      push(g, 2'b11, 2'd0);
      push(g, 2'b00, 2'd0);
    end
  endtask
  function automatic int pick(input int pe, input int px);
    int r;
    r = int'($urandom_range(0, 99));
    return r < pe ? 0 : r < pe + px ? 1 : r < 95 ? 2 : 3;
  endfunction
  task automatic step();
    @(negedge clk);
    if (qa.size() != 0) {outer_a, inner_a, comp[0]} = qa.pop_front();
    else {outer_a, inner_a, comp[0]} = 4'd0;
    if (qb.size() != 0) {outer_b, inner_b, comp[1]} = qb.pop_front();
    else {outer_b, inner_b, comp[1]} = 4'd0;
  endtask
  task automatic drain();
    while (qa.size() != 0 || qb.size() != 0) step();
    repeat (3) step();
  endtask
  initial begin
    comp[0] = 2'd0;
    comp[1] = 2'd0;
    repeat (2) @(negedge clk);
    reset = 0;
    basic(0, 1);
    drain();
    episode(0, 2);
    drain();
    for (int i = 0; i < 40; i++) begin
      episode(0, pick(85, 10));
      episode(1, pick(85, 10));
      drain();
    end
    for (int i = 0; i < 4; i++) begin
      basic(0, 1);
      basic(1, 0);
      drain();
    end
    for (int i = 0; i < 45; i++) begin
      episode(0, pick(10, 85));
      episode(1, pick(10, 85));
      drain();
    end
    for (int i = 0; i < 30; i++) begin
      episode(0, pick(45, 45));
      episode(1, pick(45, 45));
      if ($urandom_range(0, 1) != 0) drain();
      else repeat ($urandom_range(2, 6)) step();
    end
    drain();
    for (int i = 0; i < 4; i++) begin
      basic(0, 1);
      basic(1, 0);
      drain();
    end
    basic(0, 1);
    push(1, 2'b01, 2'd0);
    repeat (4) push(1, 2'b11, 2'd0);
    repeat (4) step();
    @(negedge clk);
    reset = 1;
    qa.delete();
    qb.delete();
    {outer_a, inner_a, comp[0]} = 4'd0;
    {outer_b, inner_b, comp[1]} = 4'd0;
    @(negedge clk);
    reset = 0;
    push(1, 2'b10, 2'd0);
    push(1, 2'b00, 2'd0);
    drain();
    chk("contested_seen", int'(contested > 0), 1);
    chk("full_reject_seen", int'(full_rej > 0), 1);
    chk("empty_reject_seen", int'(empty_rej > 0), 1);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
